// File: rtl/l2_miss_fill_unit.sv
// rtl/l2_miss_fill_unit.sv - L2 miss queue, victim writeback and line fill engine
package l2_miss_fill_pkg;
  typedef struct packed {
    logic [25:0] address;  // line address (byte address >> 6)
    logic [5:0]  id;
  } l2req_packet_t;
endpackage

module l2_miss_fill_unit
  import l2_miss_fill_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int BEAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  l2req_packet_t         miss_packet,
  input  logic                  miss_needs_writeback,
  input  logic [25:0]           miss_writeback_addr,
  input  logic [511:0]          miss_writeback_data,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  fill_valid,
  output l2req_packet_t         fill_packet,
  output logic [511:0]          fill_data,
  input  logic                  fill_ack,
  output logic                  pc_event_writeback
);
  localparam int LINE_BITS  = 512;
  localparam int BEATS      = LINE_BITS / BEAT_WIDTH;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int IDX_W      = $clog2(QUEUE_DEPTH);
  localparam int PTR_W      = IDX_W + 1;
  // One spare bit so an overrun of the last beat is observable
  localparam int BEAT_W     = $clog2(BEATS) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LINE_BITS-1:0] BEAT_MASK = {{(LINE_BITS-BEAT_WIDTH){1'b0}}, {BEAT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_READ, S_FILL} state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  pc_evt_q, pc_evt_d;
  logic [LINE_BITS-1:0]  line_q, line_d;

  l2req_packet_t         pkt_q  [QUEUE_DEPTH];
  l2req_packet_t         pkt_d  [QUEUE_DEPTH];
  logic                  need_q [QUEUE_DEPTH];
  logic                  need_d [QUEUE_DEPTH];
  logic [25:0]           wba_q  [QUEUE_DEPTH];
  logic [25:0]           wba_d  [QUEUE_DEPTH];
  logic [LINE_BITS-1:0]  wbd_q  [QUEUE_DEPTH];
  logic [LINE_BITS-1:0]  wbd_d  [QUEUE_DEPTH];

  logic                  empty, full, enq, deq;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [31:0]           beat_off, beat_shift;
  logic                  last_beat;

  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
  assign miss_ready = !full;
  assign enq        = miss_valid && !full;
  assign beat_off   = 32'(beat_q) * 32'(BEAT_BYTES);
  // Beat 0 is the most significant word of the line
  assign beat_shift = (32'(BEATS - 1) - 32'(beat_q)) * 32'(BEAT_WIDTH);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign pc_event_writeback = pc_evt_q;

  // Queue storage: victim address/data are captured once, at enqueue
  always_comb begin
    pkt_d  = pkt_q;
    need_d = need_q;
    wba_d  = wba_q;
    wbd_d  = wbd_q;
    if (enq) begin
      pkt_d[wr_idx]  = miss_packet;
      need_d[wr_idx] = miss_needs_writeback;
      wba_d[wr_idx]  = miss_writeback_addr;
      wbd_d[wr_idx]  = miss_writeback_data;
    end
  end

  // Pointer update; simultaneous enqueue and dequeue both take effect
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
  end

  // Head-of-queue FSM: writeback victim, read line, present fill
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pc_evt_d    = 1'b0;
    line_d      = line_q;
    deq         = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_valid  = 1'b0;
    fill_packet = '0;
    fill_data   = '0;
    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (!empty) state_d = need_q[rd_idx] ? S_WRITEBACK : S_READ;
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {wba_q[rd_idx], 6'b0} + beat_off;
        mem_wdata = BEAT_WIDTH'(wbd_q[rd_idx] >> beat_shift);
        if (mem_ack) begin
          if (last_beat) begin
            beat_d   = '0;
            pc_evt_d = 1'b1;
            state_d  = S_READ;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = {pkt_q[rd_idx].address, 6'b0} + beat_off;
        if (mem_ack) begin
          line_d = (line_q & ~(BEAT_MASK << beat_shift)) | (LINE_BITS'(mem_rdata) << beat_shift);
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        fill_valid  = 1'b1;
        fill_packet = pkt_q[rd_idx];
        fill_data   = line_q;
        if (fill_ack) begin
          deq     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pc_evt_q <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pc_evt_q <= pc_evt_d;
      line_q   <= line_d;
    end
  end

  // Queue payload needs no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    pkt_q  <= pkt_d;
    need_q <= need_d;
    wba_q  <= wba_d;
    wbd_q  <= wbd_d;
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset) !(enq && full));
  a_beat_in_range:    assert property (@(posedge clk) disable iff (reset) beat_q <= LAST_BEAT);
endmodule

// File: tb/tb_l2_miss_fill_unit.sv
// tb/tb_l2_miss_fill_unit.sv - scoreboard bench for l2_miss_fill_unit
module tb_l2_miss_fill_unit;
  import l2_miss_fill_pkg::*;

  localparam int QD = 4;

  logic           clk, reset;
  logic           miss_valid, miss_ready, miss_needs_writeback;
  l2req_packet_t  miss_packet, fill_packet;
  logic [25:0]    miss_writeback_addr;
  logic [511:0]   miss_writeback_data, fill_data;
  logic           mem_req, mem_write, mem_ack, fill_valid, fill_ack, pc_event_writeback;
  logic [31:0]    mem_addr, mem_wdata, mem_rdata;

  l2_miss_fill_unit #(.QUEUE_DEPTH(QD), .BEAT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_packet(miss_packet),
    .miss_needs_writeback(miss_needs_writeback), .miss_writeback_addr(miss_writeback_addr),
    .miss_writeback_data(miss_writeback_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_packet(fill_packet), .fill_data(fill_data),
    .fill_ack(fill_ack), .pc_event_writeback(pc_event_writeback)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          last_wb;
  } beat_t;

  typedef struct {
    logic [31:0]  pkt;
    logic [511:0] data;
  } fill_t;

  beat_t exp_beats[$];
  fill_t exp_fills[$];

  int n_checks = 0;
  int n_err    = 0;
  int ack_mode = 0;        // 0 always, 1 every 3rd cycle, 2 random, 3 never
  int fill_delay_cfg = 0;  // cycles to hold fill_ack low; negative = random
  int cur_delay = 0;
  int fill_wait = 0;
  int cyc = 0;
  bit pulse_pending = 0;
  bit deq_pending = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model: read data is a fixed function of the byte address
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bus beats and fill for one accepted miss
  task automatic push_expect(input l2req_packet_t pkt, input logic nwb,
                             input logic [25:0] wa, input logic [511:0] wd);
    beat_t b;
    fill_t f;
    if (nwb) begin
      for (int i = 0; i < 16; i++) begin
        b.wr = 1; b.addr = {wa, 6'b0} + 32'(4 * i);
        b.data = wd[511 - 32 * i -: 32]; b.last_wb = (i == 15);
        exp_beats.push_back(b);
      end
    end
    f.pkt = 32'(pkt);
    f.data = '0;
    for (int i = 0; i < 16; i++) begin
      b.wr = 0; b.addr = {pkt.address, 6'b0} + 32'(4 * i);
      b.data = rd_word(b.addr); b.last_wb = 0;
      f.data[511 - 32 * i -: 32] = b.data;
      exp_beats.push_back(b);
    end
    exp_fills.push_back(f);
  endtask

  // Offer a miss; the model decides when the queue has room
  task automatic send(input l2req_packet_t pkt, input logic nwb,
                      input logic [25:0] wa, input logic [511:0] wd);
    int waited = 0;
    bit exp_ready;
    forever begin
      @(negedge clk); #1;
      exp_ready = (exp_fills.size() + int'(deq_pending)) < QD;
      check("miss_ready", 512'(miss_ready), 512'(exp_ready));
      miss_packet = pkt; miss_needs_writeback = nwb;
      miss_writeback_addr = wa; miss_writeback_data = wd;
      miss_valid = 1'b1;
      if (exp_ready) begin
        push_expect(pkt, nwb, wa, wd);
        break;
      end
      waited++;
      if (waited > 5000) begin
        check("miss_accept_timeout", 512'(miss_ready), 512'(1));
        break;
      end
    end
    @(posedge clk); #1;
    miss_valid = 1'b0;
    miss_packet = '0; miss_needs_writeback = 0;
    miss_writeback_addr = '0; miss_writeback_data = '0;
  endtask

  task automatic send_random();
    l2req_packet_t p;
    logic [511:0] wd;
    p = {26'($urandom), 6'($urandom)};
    for (int i = 0; i < 16; i++) wd[32 * i +: 32] = $urandom;
    send(p, 1'($urandom_range(0, 1)), 26'($urandom), wd);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_fills.size() != 0 || exp_beats.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_fills", 512'(exp_fills.size()), 512'(0));
    @(negedge clk); #1;
    check("idle_fill_valid", 512'(fill_valid), 512'(0));
  endtask

  // Monitor: memory responder, fill acceptor and scoreboard comparisons
  always @(negedge clk) begin
    beat_t b;
    fill_t f;
    logic mack;
    cyc++;
    deq_pending = 1'b0;
    if (reset) begin
      mem_ack = 1'b0; fill_ack = 1'b0; fill_wait = 0; pulse_pending = 0;
    end else begin
      if (pulse_pending || pc_event_writeback)
        check("pc_event_writeback", 512'(pc_event_writeback), 512'(pulse_pending));
      pulse_pending = 0;
      case (ack_mode)
        0: mack = 1'b1;
        1: mack = (cyc % 3 == 0);
        2: mack = 1'($urandom_range(0, 1));
        default: mack = 1'b0;
      endcase
      if (mem_req) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_mem_req", 512'(mem_req), 512'(0));
          mack = 1'b0;
        end else begin
          b = exp_beats[0];
          check("mem_write", 512'(mem_write), 512'(b.wr));
          check("mem_addr", 512'(mem_addr), 512'(b.addr));
          if (b.wr) check("mem_wdata", 512'(mem_wdata), 512'(b.data));
          if (mack) begin
            if (!b.wr) mem_rdata = rd_word(b.addr);
            void'(exp_beats.pop_front());
            if (b.last_wb) pulse_pending = 1;
          end
        end
      end else if (mack) begin
        mem_rdata = $urandom;
      end
      mem_ack = mack;

      if (fill_valid) begin
        if (exp_fills.size() == 0) begin
          check("unexpected_fill", 512'(fill_valid), 512'(0));
          fill_ack = 1'b0;
        end else begin
          f = exp_fills[0];
          check("fill_packet", 512'(fill_packet), 512'(f.pkt));
          check("fill_data", fill_data, f.data);
          if (fill_wait == 0)
            cur_delay = (fill_delay_cfg < 0) ? int'($urandom_range(0, 3)) : fill_delay_cfg;
          if (fill_wait >= cur_delay) begin
            fill_ack = 1'b1;
            void'(exp_fills.pop_front());
            deq_pending = 1'b1;
            fill_wait = 0;
          end else begin
            fill_ack = 1'b0;
            fill_wait++;
          end
        end
      end else begin
        fill_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin
    logic [511:0] wd;
    int n;
    reset = 1'b1; miss_valid = 0; miss_packet = '0; miss_needs_writeback = 0;
    miss_writeback_addr = '0; miss_writeback_data = '0;
    mem_ack = 0; mem_rdata = '0; fill_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_miss_ready", 512'(miss_ready), 512'(1));
    check("reset_mem_req", 512'(mem_req), 512'(0));
    check("reset_mem_addr", 512'(mem_addr), 512'(0));
    check("reset_fill_valid", 512'(fill_valid), 512'(0));
    check("reset_fill_data", fill_data, 512'(0));
    check("reset_pc_event", 512'(pc_event_writeback), 512'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Clean miss, every beat acked at once
    ack_mode = 0; fill_delay_cfg = 0;
    send({26'h0000100, 6'h01}, 1'b0, 26'h0, 512'h0);
    wait_drain();
    check("clean_miss_ready", 512'(miss_ready), 512'(1));

    // Dirty miss: victim word i carries value i
    for (int i = 0; i < 16; i++) wd[511 - 32 * i -: 32] = 32'(i);
    send({26'h0000155, 6'h02}, 1'b1, 26'h0000200, wd);
    wait_drain();

    // Backpressure on both the bus and the fill port
    ack_mode = 1; fill_delay_cfg = 10;
    send_random();
    send({26'h3ABCDEF, 6'h03}, 1'b1, 26'h1234567, {16{32'hCAFE0000}} ^ wd);
    wait_drain();

    // Fill the queue with the bus stalled, then a 5th offer waits for room
    ack_mode = 3; fill_delay_cfg = 0;
    for (int i = 0; i < 4; i++) send_random();
    fork
      send_random();
      begin
        repeat (8) @(negedge clk);
        ack_mode = 0;
      end
    join
    for (int i = 0; i < 4; i++) send_random();
    wait_drain();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      ack_mode = (i % 10 < 7) ? 2 : int'($urandom_range(0, 1));
      fill_delay_cfg = -1;
      send_random();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    // Reset while the 7th read beat is outstanding
    ack_mode = 0; fill_delay_cfg = 0;
    send({26'h0000777, 6'h07}, 1'b0, 26'h0, 512'h0);
    n = 0;
    while (exp_beats.size() > 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_beat7", 512'(exp_beats.size()), 512'(10));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midreset_mem_req", 512'(mem_req), 512'(0));
    check("midreset_fill_valid", 512'(fill_valid), 512'(0));
    check("midreset_miss_ready", 512'(miss_ready), 512'(1));
    exp_beats.delete();
    exp_fills.delete();
    pulse_pending = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("postreset_idle", 512'(mem_req), 512'(0));
    end
    send({26'h0000888, 6'h08}, 1'b1, 26'h0000999, wd);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_miss_fill_unit.md
Name: l2_miss_fill_unit

Overview:
- Memory-side responder for L2 misses; sits between the L2 pipeline read/miss stage, the system memory bus and the L2 request arbiter.
- Queues missed requests and writes back the dirty victim line to memory in beats.
- Reads the missing line in beats, assembles it into a full cache line, and re-presents the original request to the arbiter as a fill.
- Its output is the source of the arbiter's fill-flag and fill-data inputs.

Parameters:
- QUEUE_DEPTH, 4, number of outstanding miss entries; power of two, ≥2.
- BEAT_WIDTH, 32, memory bus data width in bits; divides `CACHE_LINE_BITS (512); BEATS = 512/BEAT_WIDTH = 16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- miss_valid  in  1  a miss entry is offered.
- miss_ready  out  1  queue can accept an entry (= !full).
- miss_packet  in  l2req_packet_t  original request; returned unchanged.
- miss_needs_writeback  in  1  victim line is valid and dirty.
- miss_writeback_addr  in  26  victim line address (byte address >> 6).
- miss_writeback_data  in  512  victim line data.
- mem_req  out  1  bus request.
- mem_write  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  byte address of current beat.
- mem_wdata  out  BEAT_WIDTH  write beat data.
- mem_ack  in  1  beat completes this cycle.
- mem_rdata  in  BEAT_WIDTH  read data; valid when mem_ack & !mem_write.
- fill_valid  out  1  fill ready for the arbiter.
- fill_packet  out  l2req_packet_t  original request of the fill.
- fill_data  out  512  assembled line.
- fill_ack  in  1  arbiter accepted the fill.
- pc_event_writeback  out  1  one-cycle pulse when a writeback completes.

Behaviour:
- Reset values:
  - All outputs 0, except miss_ready = 1.
  - Queue empty, FSM in IDLE, beat counter 0.
- Queue:
  - Circular FIFO with read/write pointers of log2(QUEUE_DEPTH)+1 bits; both pointers wrap.
  - Enqueue when miss_valid & miss_ready.
  - Dequeue when the FSM leaves FILL on fill_ack.
  - Enqueue and dequeue in the same cycle are both performed.
  - An enqueue into an empty queue is visible to IDLE the next cycle (1-cycle minimum latency).
- FSM states: IDLE, WRITEBACK, READ, FILL.
  - IDLE: if the queue is non-empty, go to WRITEBACK when the head needs_writeback is set, else to READ. Beat counter cleared.
  - WRITEBACK: mem_req=1, mem_write=1.
    - mem_addr = {wb_addr, 6'b0} + beat*4.
    - mem_wdata = wb_data[511 - beat*32 -: 32]: beat 0 is the most significant word.
    - On mem_ack, beat increments. On mem_ack with beat==15: beat←0, pulse pc_event_writeback, go to READ.
  - READ: mem_req=1, mem_write=0, mem_addr = {packet.address, 6'b0} + beat*4.
    - On mem_ack, mem_rdata is stored into line buffer bits [511 - beat*32 -: 32] and beat increments.
    - On mem_ack with beat==15: go to FILL.
  - FILL: fill_valid=1; fill_packet = head packet; fill_data = line buffer.
    - All three are held stable until fill_ack.
    - On fill_ack: dequeue, go to IDLE. fill_valid drops the next cycle.
- Memory handshake:
  - mem_req, mem_addr, mem_write and mem_wdata stay stable until mem_ack.
  - Back-to-back beats are allowed: mem_req stays high after an ack that is not the last beat.
  - mem_ack while mem_req=0 is ignored.
- Miss-queue behaviour:
  - The queue captures the writeback address and data at enqueue. The victim data must not be read again later.
  - miss_ready is a pure function of queue state, with no combinational path from miss_valid.
  - When full, miss_valid is ignored; the entry is not lost, because the upstream stage holds it.
- Ordering: fills are returned strictly in enqueue order; one memory transaction is in flight at a time.
- fill_ack while fill_valid=0 is ignored.
- Reset mid-operation: async clear of queue, FSM and beat counter.
  - mem_req and fill_valid drop immediately.
  - A partial writeback or read is abandoned and not resumed.
- Assertions:
  - No enqueue while full.
  - The beat counter never exceeds 15.

Test Plan:
- Clean miss: enqueue address 0x0000100 with no writeback; ack every beat.
  -> 16 reads at 0x00004000..0x0000403C. fill_valid rises the cycle after the 16th ack, with fill_data = read words (beat 0 in [511:480]). fill_ack → fill_valid=0 and miss_ready=1.
- Dirty miss: enqueue with writeback address 0x0000200 and data = 0x00..0F per word.
  -> 16 writes at 0x00008000+4i with mem_wdata=i, then a pc_event_writeback pulse, then 16 reads, then the fill.
- Backpressure: ack a beat only every 3rd cycle, and hold fill_ack low 10 cycles.
  -> mem_addr, mem_wdata, fill_packet and fill_data stay stable while waiting. Exactly 16 beats are issued.
- Queue full: enqueue 4 misses with no mem_ack.
  -> miss_ready=0. A 5th miss_valid is ignored. After the first fill_ack, miss_ready=1 the next cycle and the fills emerge in FIFO order.
- Simultaneous: with the queue full, a fill_ack and an enqueue arrive in the same cycle.
  -> count stays 4, and the pointers wrap correctly over 8 total entries.
- Reset during the 7th read beat.
  -> mem_req=0 and fill_valid=0 immediately, and the queue is empty. A fresh miss after reset completes normally, starting at beat 0.
